data_array_access_scheduler: RTL and testbench



---
 rtl/data_array_sched_pkg.sv | 32 +++
 rtl/data_array_flush_walker.sv | 58 +++++
 rtl/data_array_access_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_data_array_access_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_array_sched_pkg.sv
// Shared types for the data-array access scheduler: FSM states, in-flight read owner
// encoding and a one-hot to index helper (one-hot inputs up to 64 bits wide).
package data_array_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_CORE  = 2'd1,
    OWN_FLUSH = 2'd2
  } owner_e;

  localparam int unsigned ONEHOT_MAX_WIDTH = 64;

  function automatic logic [31:0] onehot_to_index(input logic [ONEHOT_MAX_WIDTH-1:0] onehot);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = 0; i < ONEHOT_MAX_WIDTH; i++) begin
      if (onehot[i]) begin
        idx = idx | 32'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/data_array_flush_walker.sv
// Set/way walker for the flush sweep: way advances first, set advances on way wrap.
// The way is kept one-hot so it can drive the array directly; the index is decoded from it.
module data_array_flush_walker
  import data_array_sched_pkg::*;
#(
  parameter int unsigned NUMBER_SETS           = 64,
  parameter int unsigned NUMBER_WAYS           = 16,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SETS),
  parameter int unsigned WAY_PTR_WIDTH_IN_BITS = $clog2(NUMBER_WAYS)
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             restart_in,
  input  logic                             advance_in,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0] set_out,
  output logic [NUMBER_WAYS-1:0]           way_onehot_out,
  output logic [WAY_PTR_WIDTH_IN_BITS-1:0] way_index_out,
  output logic                             last_out
);

  logic [SET_PTR_WIDTH_IN_BITS-1:0] set_r;
  logic [NUMBER_WAYS-1:0]           way_oh_r;
  logic [ONEHOT_MAX_WIDTH-1:0]      way_oh_ext_s;
  logic                             way_wrap_s;
  logic                             last_set_s;

  // Position counters; restart returns to element (0,0)
  always_ff @(posedge clk_in) begin
    if (reset_in || restart_in) begin
      set_r    <= '0;
      way_oh_r <= NUMBER_WAYS'(1);
    end else if (advance_in) begin
      if (way_wrap_s) begin
        way_oh_r <= NUMBER_WAYS'(1);
        set_r    <= last_set_s ? '0 : set_r + SET_PTR_WIDTH_IN_BITS'(1);
      end else begin
        way_oh_r <= way_oh_r << 1;
        set_r    <= set_r;
      end
    end else begin
      set_r    <= set_r;
      way_oh_r <= way_oh_r;
    end
  end

  // Wrap / last-element detection and way index decode
  always_comb begin
    way_wrap_s   = way_oh_r[NUMBER_WAYS-1];
    last_set_s   = (set_r == SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1));
    way_oh_ext_s = '0;
    way_oh_ext_s[NUMBER_WAYS-1:0] = way_oh_r;
    way_index_out  = WAY_PTR_WIDTH_IN_BITS'(onehot_to_index(way_oh_ext_s));
    set_out        = set_r;
    way_onehot_out = way_oh_r;
    last_out       = way_wrap_s && last_set_s;
  end

endmodule

// File: rtl/data_array_access_scheduler.sv
// Arbitrates the single data-array port between refill, core and the flush sweep.
// Optional build macro DATA_ARRAY_STARVATION_GUARD_EN forces a core grant after STARVE_LIMIT losses.
module data_array_access_scheduler
  import data_array_sched_pkg::*;
#(
  parameter int unsigned SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int unsigned NUMBER_SETS                 = 64,
  parameter int unsigned NUMBER_WAYS                 = 16,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
  parameter int unsigned WAY_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_WAYS),
  parameter int unsigned STARVE_LIMIT                = 4
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   core_req_valid_in,
  output logic                                   core_req_ready_out,
  input  logic                                   core_req_write_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       core_req_set_in,
  input  logic [NUMBER_WAYS-1:0]                 core_req_way_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] core_req_data_in,
  output logic                                   core_resp_valid_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] core_resp_data_out,
  input  logic                                   refill_req_valid_in,
  output logic                                   refill_req_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       refill_req_set_in,
  input  logic [NUMBER_WAYS-1:0]                 refill_req_way_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] refill_req_data_in,
  input  logic                                   flush_start_in,
  output logic                                   flush_busy_out,
  output logic                                   flush_done_out,
  output logic                                   flush_data_valid_out,
  input  logic                                   flush_data_ready_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] flush_data_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       flush_set_out,
  output logic [WAY_PTR_WIDTH_IN_BITS-1:0]       flush_way_out,
  output logic                                   array_access_en_out,
  output logic                                   array_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       array_set_addr_out,
  output logic [NUMBER_WAYS-1:0]                 array_way_select_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] array_write_data_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] array_read_data_in
);

  sched_state_e state_r, state_next_s;
  owner_e       owner_r, owner_next_s;

  logic refill_fire_s, core_fire_s, sweep_issue_s, drain_done_s, force_core_s;

  logic                                   flush_valid_r;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] flush_data_r;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       flush_set_r;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0]       flush_way_r;

  logic [SET_PTR_WIDTH_IN_BITS-1:0] walk_set_s;
  logic [NUMBER_WAYS-1:0]           walk_way_oh_s;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] walk_way_idx_s;
  logic                             walk_last_s;

  data_array_flush_walker #(
    .NUMBER_SETS          (NUMBER_SETS),
    .NUMBER_WAYS          (NUMBER_WAYS),
    .SET_PTR_WIDTH_IN_BITS(SET_PTR_WIDTH_IN_BITS),
    .WAY_PTR_WIDTH_IN_BITS(WAY_PTR_WIDTH_IN_BITS)
  ) u_walker (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .restart_in    ((state_r == ST_IDLE) && flush_start_in),
    .advance_in    (sweep_issue_s),
    .set_out       (walk_set_s),
    .way_onehot_out(walk_way_oh_s),
    .way_index_out (walk_way_idx_s),
    .last_out      (walk_last_s)
  );

`ifdef DATA_ARRAY_STARVATION_GUARD_EN
  localparam int unsigned STARVE_CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_r;

  // Saturating count of consecutive cycles where a waiting core lost to refill
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      starve_cnt_r <= '0;
    end else if (core_fire_s || !core_req_valid_in) begin
      starve_cnt_r <= '0;
    end else if (refill_fire_s && !force_core_s) begin
      starve_cnt_r <= starve_cnt_r + STARVE_CNT_WIDTH'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Core wins the next contention once the limit is reached
  always_comb force_core_s = (starve_cnt_r >= STARVE_CNT_WIDTH'(STARVE_LIMIT));
`else
  // Strict refill-over-core priority
  always_comb force_core_s = 1'b0;
`endif

  // State and in-flight owner registers
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_NONE;
    end else begin
      state_r <= state_next_s;
      owner_r <= owner_next_s;
    end
  end

  // Next-state and next in-flight owner
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = flush_start_in ? ST_SWEEP : ST_IDLE;
      ST_SWEEP: state_next_s = (sweep_issue_s && walk_last_s) ? ST_DRAIN : ST_SWEEP;
      ST_DRAIN: state_next_s = drain_done_s ? ST_IDLE : ST_DRAIN;
      default:  state_next_s = ST_IDLE;
    endcase
    if (core_fire_s && !core_req_write_in) begin
      owner_next_s = OWN_CORE;
    end else if (sweep_issue_s) begin
      owner_next_s = OWN_FLUSH;
    end else begin
      owner_next_s = OWN_NONE;
    end
  end

  // Grants, array command, response routing and status
  always_comb begin
    if (!reset_in && (state_r == ST_IDLE)) begin
      refill_req_ready_out = !(force_core_s && core_req_valid_in);
      core_req_ready_out   = force_core_s || !refill_req_valid_in;
    end else begin
      refill_req_ready_out = 1'b0;
      core_req_ready_out   = 1'b0;
    end
    refill_fire_s = refill_req_valid_in && refill_req_ready_out;
    core_fire_s   = core_req_valid_in && core_req_ready_out;
    // a sweep read needs a free return slot and room in the flush register
    sweep_issue_s = !reset_in && (state_r == ST_SWEEP) && (owner_r == OWN_NONE) &&
                    (!flush_valid_r || flush_data_ready_in);
    drain_done_s  = (state_r == ST_DRAIN) && (owner_r == OWN_NONE) && !flush_valid_r;

    flush_done_out      = drain_done_s && !reset_in;
    flush_busy_out      = (state_r != ST_IDLE);
    core_resp_valid_out = (owner_r == OWN_CORE);
    core_resp_data_out  = core_resp_valid_out ? array_read_data_in : '0;

    array_access_en_out  = 1'b0;
    array_write_en_out   = 1'b0;
    array_set_addr_out   = '0;
    array_way_select_out = '0;
    array_write_data_out = '0;
    if (refill_fire_s) begin
      array_access_en_out  = 1'b1;
      array_write_en_out   = 1'b1;
      array_set_addr_out   = refill_req_set_in;
      array_way_select_out = refill_req_way_in;
      array_write_data_out = refill_req_data_in;
    end else if (core_fire_s) begin
      array_access_en_out  = 1'b1;
      array_write_en_out   = core_req_write_in;
      array_set_addr_out   = core_req_set_in;
      array_way_select_out = core_req_way_in;
      array_write_data_out = core_req_data_in;
    end else if (sweep_issue_s) begin
      array_access_en_out  = 1'b1;
      array_set_addr_out   = walk_set_s;
      array_way_select_out = walk_way_oh_s;
    end else begin
      array_access_en_out  = 1'b0;
    end
  end

  // Flush output register: loads on a returning sweep read, holds until accepted
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      flush_valid_r <= 1'b0;
      flush_data_r  <= '0;
      flush_set_r   <= '0;
      flush_way_r   <= '0;
    end else begin
      if (owner_r == OWN_FLUSH) begin
        flush_valid_r <= 1'b1;
        flush_data_r  <= array_read_data_in;
      end else if (flush_data_ready_in) begin
        flush_valid_r <= 1'b0;
        flush_data_r  <= flush_data_r;
      end else begin
        flush_valid_r <= flush_valid_r;
        flush_data_r  <= flush_data_r;
      end
      if (sweep_issue_s) begin
        flush_set_r <= walk_set_s;
        flush_way_r <= walk_way_idx_s;
      end else begin
        flush_set_r <= flush_set_r;
        flush_way_r <= flush_way_r;
      end
    end
  end

  assign flush_data_valid_out = flush_valid_r;
  assign flush_data_out       = flush_data_r;
  assign flush_set_out        = flush_set_r;
  assign flush_way_out        = flush_way_r;

endmodule

// File: tb/tb_data_array_access_scheduler.sv
// Directed bench for data_array_access_scheduler on a 4-set x 4-way, 32-bit array model.
module tb_data_array_access_scheduler;

  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned NW = 4;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic          core_req_valid_in, core_req_ready_out, core_req_write_in;
  logic [1:0]    core_req_set_in;
  logic [NW-1:0] core_req_way_in;
  logic [DW-1:0] core_req_data_in;
  logic          core_resp_valid_out;
  logic [DW-1:0] core_resp_data_out;
  logic          refill_req_valid_in, refill_req_ready_out;
  logic [1:0]    refill_req_set_in;
  logic [NW-1:0] refill_req_way_in;
  logic [DW-1:0] refill_req_data_in;
  logic          flush_start_in, flush_busy_out, flush_done_out;
  logic          flush_data_valid_out, flush_data_ready_in;
  logic [DW-1:0] flush_data_out;
  logic [1:0]    flush_set_out;
  logic [1:0]    flush_way_out;
  logic          array_access_en_out, array_write_en_out;
  logic [1:0]    array_set_addr_out;
  logic [NW-1:0] array_way_select_out;
  logic [DW-1:0] array_write_data_out;
  logic [DW-1:0] array_read_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [NS][NW];

  data_array_access_scheduler #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(DW), .NUMBER_SETS(NS), .NUMBER_WAYS(NW), .STARVE_LIMIT(4)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .core_req_valid_in(core_req_valid_in), .core_req_ready_out(core_req_ready_out),
    .core_req_write_in(core_req_write_in), .core_req_set_in(core_req_set_in),
    .core_req_way_in(core_req_way_in), .core_req_data_in(core_req_data_in),
    .core_resp_valid_out(core_resp_valid_out), .core_resp_data_out(core_resp_data_out),
    .refill_req_valid_in(refill_req_valid_in), .refill_req_ready_out(refill_req_ready_out),
    .refill_req_set_in(refill_req_set_in), .refill_req_way_in(refill_req_way_in),
    .refill_req_data_in(refill_req_data_in),
    .flush_start_in(flush_start_in), .flush_busy_out(flush_busy_out), .flush_done_out(flush_done_out),
    .flush_data_valid_out(flush_data_valid_out), .flush_data_ready_in(flush_data_ready_in),
    .flush_data_out(flush_data_out), .flush_set_out(flush_set_out), .flush_way_out(flush_way_out),
    .array_access_en_out(array_access_en_out), .array_write_en_out(array_write_en_out),
    .array_set_addr_out(array_set_addr_out), .array_way_select_out(array_way_select_out),
    .array_write_data_out(array_write_data_out), .array_read_data_in(array_read_data)
  );

  always #5 clk_in = ~clk_in;

  function automatic int oh2i(input logic [NW-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < int'(NW); i++) if (oh[i]) idx = i;
    return idx;
  endfunction

  function automatic logic [DW-1:0] pat(input int s, input int w);
    return 32'hC0DE_0000 + 32'(s * 256 + w);
  endfunction

  // contents the sweep should find after the writes the bench issues
  function automatic logic [DW-1:0] exp_data(input int s, input int w);
    if (s == 1 && w == 1) return 32'h1234_5678;
    if (s == 2 && w == 3) return 32'hFEED_BEEF;
    return pat(s, w);
  endfunction

  // Array model: per-way single-port RAM, registered read
  always @(posedge clk_in) begin
    if (reset_in) begin
      for (int s = 0; s < int'(NS); s++)
        for (int w = 0; w < int'(NW); w++) mem[s][w] <= pat(s, w);
      array_read_data <= '0;
    end else if (array_access_en_out) begin
      if (array_write_en_out) mem[array_set_addr_out][oh2i(array_way_select_out)] <= array_write_data_out;
      else array_read_data <= mem[array_set_addr_out][oh2i(array_way_select_out)];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_rdy"}, 64'(core_req_ready_out), 64'd0);
    check({tag, "_refill_rdy"}, 64'(refill_req_ready_out), 64'd0);
    check({tag, "_resp_v"}, 64'(core_resp_valid_out), 64'd0);
    check({tag, "_resp_d"}, 64'(core_resp_data_out), 64'd0);
    check({tag, "_busy"}, 64'(flush_busy_out), 64'd0);
    check({tag, "_done"}, 64'(flush_done_out), 64'd0);
    check({tag, "_fv"}, 64'(flush_data_valid_out), 64'd0);
    check({tag, "_fdata"}, 64'({flush_data_out, flush_set_out, flush_way_out}), 64'd0);
    check({tag, "_acc"}, 64'({array_access_en_out, array_write_en_out, array_set_addr_out,
                             array_way_select_out}), 64'd0);
  endtask

  int k;
  int done_cnt;
  int acc;
  logic [DW-1:0] hold_data;
  logic [1:0] hold_set, hold_way;

  initial begin
    reset_in = 1'b1;
    core_req_valid_in = 1'b0; core_req_write_in = 1'b0; core_req_set_in = 2'd0;
    core_req_way_in = 4'd0; core_req_data_in = 32'd0;
    refill_req_valid_in = 1'b0; refill_req_set_in = 2'd0; refill_req_way_in = 4'd0;
    refill_req_data_in = 32'd0; flush_start_in = 1'b0; flush_data_ready_in = 1'b0;
    tick(); tick();
    check_all_zero("rst");
    reset_in = 1'b0;
    tick();
    check("idle_core_rdy", 64'(core_req_ready_out), 64'd1);

    // core read set 3 way 0x4
    core_req_valid_in = 1'b1; core_req_set_in = 2'd3; core_req_way_in = 4'b0100; #1;
    check("rd_acc", 64'({array_access_en_out, array_write_en_out}), 64'b10);
    check("rd_addr", 64'({array_set_addr_out, array_way_select_out}), 64'({2'd3, 4'b0100}));
    tick(); core_req_valid_in = 1'b0;
    check("rd_resp_v", 64'(core_resp_valid_out), 64'd1);
    check("rd_resp_d", 64'(core_resp_data_out), 64'(pat(3, 2)));
    tick();
    check("rd_resp_v_off", 64'(core_resp_valid_out), 64'd0);

    // core write then read back
    core_req_valid_in = 1'b1; core_req_write_in = 1'b1; core_req_set_in = 2'd1;
    core_req_way_in = 4'b0010; core_req_data_in = 32'h1234_5678; #1;
    check("wr_we", 64'({array_access_en_out, array_write_en_out}), 64'b11);
    check("wr_data", 64'(array_write_data_out), 64'h1234_5678);
    tick(); core_req_write_in = 1'b0;
    check("wr_no_resp", 64'(core_resp_valid_out), 64'd0);
    tick(); core_req_valid_in = 1'b0;
    check("rb_resp_d", 64'({core_resp_valid_out, core_resp_data_out}), 64'({1'b1, 32'h1234_5678}));

    // contention: refill wins (guard build: core wins the 5th contending cycle)
    core_req_valid_in = 1'b1; core_req_write_in = 1'b1; core_req_set_in = 2'd0;
    core_req_way_in = 4'b0001; core_req_data_in = pat(0, 0);
    refill_req_valid_in = 1'b1; refill_req_set_in = 2'd2; refill_req_way_in = 4'b1000;
    refill_req_data_in = 32'hFEED_BEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
`ifdef DATA_ARRAY_STARVATION_GUARD_EN
      check("cont_core_rdy", 64'(core_req_ready_out), (i == 4) ? 64'd1 : 64'd0);
      check("cont_refill_rdy", 64'(refill_req_ready_out), (i == 4) ? 64'd0 : 64'd1);
`else
      check("cont_core_rdy", 64'(core_req_ready_out), 64'd0);
      check("cont_refill_rdy", 64'(refill_req_ready_out), 64'd1);
      check("cont_addr", 64'({array_write_en_out, array_set_addr_out, array_way_select_out}),
            64'({1'b1, 2'd2, 4'b1000}));
`endif
      tick();
    end
    core_req_valid_in = 1'b0; refill_req_valid_in = 1'b0; core_req_write_in = 1'b0;
    tick();

    // flush start with a same-cycle core read; full sweep with a mid-sweep stall
    flush_start_in = 1'b1; core_req_valid_in = 1'b1; core_req_set_in = 2'd3; core_req_way_in = 4'b0100;
    flush_data_ready_in = 1'b1;
    tick();
    flush_start_in = 1'b0; core_req_valid_in = 1'b0;
    check("fs_busy", 64'(flush_busy_out), 64'd1);
    check("fs_resp", 64'({core_resp_valid_out, core_resp_data_out}), 64'({1'b1, pat(3, 2)}));
    check("fs_rdy", 64'({core_req_ready_out, refill_req_ready_out}), 64'd0);
    k = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      flush_start_in = (cyc == 3);
      if (flush_done_out) done_cnt++;
      if (flush_data_valid_out) begin
        if (k < 16) begin
          check("sw_set", 64'(flush_set_out), 64'(k / 4));
          check("sw_way", 64'(flush_way_out), 64'(k % 4));
          check("sw_data", 64'(flush_data_out), 64'(exp_data(k / 4, k % 4)));
        end
        k++;
        if (k == 5) begin
          flush_data_ready_in = 1'b0;
          hold_data = flush_data_out; hold_set = flush_set_out; hold_way = flush_way_out;
          acc = 0;
          for (int h = 0; h < 10; h++) begin
            tick();
            acc += int'(array_access_en_out);
            check("hold_v", 64'(flush_data_valid_out), 64'd1);
            check("hold_stable", 64'({flush_data_out, flush_set_out, flush_way_out}),
                  64'({hold_data, hold_set, hold_way}));
          end
          check("hold_acc_le1", 64'(acc <= 1), 64'd1);
          flush_data_ready_in = 1'b1;
        end
      end
      tick();
    end
    check("sw_count", 64'(k), 64'd16);
    check("sw_done_once", 64'(done_cnt), 64'd1);
    check("sw_idle", 64'(flush_busy_out), 64'd0);

    // reset during sweep aborts without a done pulse
    flush_start_in = 1'b1;
    tick();
    flush_start_in = 1'b0;
    repeat (5) tick();
    check("pre_rst_busy", 64'(flush_busy_out), 64'd1);
    reset_in = 1'b1;
    tick();
    check_all_zero("midrst");
    reset_in = 1'b0;
    done_cnt = 0; acc = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (flush_done_out) done_cnt++;
      if (flush_data_valid_out) acc++;
    end
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    check("midrst_no_fdata", 64'(acc), 64'd0);
    check("midrst_idle", 64'({flush_busy_out, core_req_ready_out}), 64'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
